input_conditioner: RTL and testbench

- Conditions the raw vehicle switch inputs (brake pedal, hidden switch, ignition key, driver door) before they reach the fuel-pump controller and the anti-theft logic.
- Per channel: 2-flop synchronizer, then a stability-counter debouncer.
- Outputs are clean registered levels plus one-cycle rise/fall event pulses.
- Sits directly upstream of the fuel-pump FSM; its `brake`, `hidden_sw` and `ignition` outputs drive that FSM's inputs.

---
 rtl/input_conditioner_if.sv | 23 ++
 rtl/input_conditioner.sv | 72 +++++++
 tb/tb_input_conditioner.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw switch inputs and conditioned levels/events bundle
interface input_conditioner_if;
  logic       brake_raw;
  logic       hidden_sw_raw;
  logic       ignition_raw;
  logic       door_drv_raw;
  logic       brake;
  logic       hidden_sw;
  logic       ignition;
  logic       door_drv;
  logic [3:0] rise;
  logic [3:0] fall;

  modport master (
    output brake_raw, hidden_sw_raw, ignition_raw, door_drv_raw,
    input  brake, hidden_sw, ignition, door_drv, rise, fall
  );

  modport slave (
    input  brake_raw, hidden_sw_raw, ignition_raw, door_drv_raw,
    output brake, hidden_sw, ignition, door_drv, rise, fall
  );
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel 2-flop synchronizer plus stability-counter debouncer
// Channel index order: [3]=door_drv, [2]=ignition, [1]=hidden_sw, [0]=brake.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input logic            clock,
  input logic            reset,
  input_conditioner_if.slave io
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       s1_q, s2_q;
  logic [3:0]       clean_q, clean_d;
  logic [3:0]       rise_q, rise_d;
  logic [3:0]       fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  assign raw = {io.door_drv_raw, io.ignition_raw, io.hidden_sw_raw, io.brake_raw};

  // Any sample matching the clean level restarts the count, so a glitch never accumulates.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = s2_q[i];
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io.brake     = clean_q[0];
  assign io.hidden_sw = clean_q[1];
  assign io.ignition  = clean_q[2];
  assign io.door_drv  = clean_q[3];
  assign io.rise      = rise_q;
  assign io.fall      = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner
module tb_input_conditioner;

  typedef struct {
    int         at_edge;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lvl;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  input_conditioner_if cond_if ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (cond_if)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic logic [3:0] lvl_now();
    return {cond_if.door_drv, cond_if.ignition, cond_if.hidden_sw, cond_if.brake};
  endfunction

  // Monitor: reset state while held, otherwise pop one expectation per observed event.
  always @(negedge clock) begin
    ev_t e;
    if (reset) begin
      checks++;
      if (lvl_now() != 4'b0 || cond_if.rise != 4'b0 || cond_if.fall != 4'b0) begin
        errors++;
        $display("FAIL reset_state: lvl=%b rise=%b fall=%b, want all 0",
                 lvl_now(), cond_if.rise, cond_if.fall);
      end
    end else if ((cond_if.rise | cond_if.fall) != 4'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: edge=%0d rise=%b fall=%b lvl=%b, want no event",
                 edge_cnt - 1, cond_if.rise, cond_if.fall, lvl_now());
      end else begin
        e = exp_q.pop_front();
        if (e.at_edge != edge_cnt - 1 || e.rise != cond_if.rise ||
            e.fall != cond_if.fall || e.lvl != lvl_now()) begin
          errors++;
          $display("FAIL event: got edge=%0d rise=%b fall=%b lvl=%b, want edge=%0d rise=%b fall=%b lvl=%b",
                   edge_cnt - 1, cond_if.rise, cond_if.fall, lvl_now(),
                   e.at_edge, e.rise, e.fall, e.lvl);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic expect_ev(input int dly, input logic [3:0] r, input logic [3:0] f,
                           input logic [3:0] l);
    ev_t e;
    e.at_edge = edge_cnt + dly;
    e.rise    = r;
    e.fall    = f;
    e.lvl     = l;
    exp_q.push_back(e);
  endtask

  initial begin
    cond_if.brake_raw     = 1'b1;
    cond_if.hidden_sw_raw = 1'b1;
    cond_if.ignition_raw  = 1'b1;
    cond_if.door_drv_raw  = 1'b1;
    idle(3);

    // Power-up with all switches closed
    reset = 1'b0;
    expect_ev(5, 4'b1111, 4'b0000, 4'b1111);
    idle(8);

    cond_if.brake_raw     = 1'b0;
    cond_if.hidden_sw_raw = 1'b0;
    cond_if.ignition_raw  = 1'b0;
    cond_if.door_drv_raw  = 1'b0;
    expect_ev(5, 4'b0000, 4'b1111, 4'b0000);
    idle(8);

    // Ignition latency
    cond_if.ignition_raw = 1'b1;
    expect_ev(5, 4'b0100, 4'b0000, 4'b0100);
    idle(8);

    // Three-cycle brake glitch is rejected
    cond_if.brake_raw = 1'b1;
    idle(3);
    cond_if.brake_raw = 1'b0;
    idle(8);

    // Six-cycle brake press is accepted, then released
    cond_if.brake_raw = 1'b1;
    expect_ev(5, 4'b0001, 4'b0000, 4'b0101);
    idle(6);
    cond_if.brake_raw = 1'b0;
    expect_ev(5, 4'b0000, 4'b0001, 4'b0100);
    idle(8);

    // Hidden switch bounce train
    cond_if.hidden_sw_raw = 1'b1;
    idle(1);
    cond_if.hidden_sw_raw = 1'b0;
    idle(1);
    cond_if.hidden_sw_raw = 1'b1;
    idle(1);
    cond_if.hidden_sw_raw = 1'b0;
    idle(1);
    cond_if.hidden_sw_raw = 1'b1;
    expect_ev(5, 4'b0010, 4'b0000, 4'b0110);
    idle(8);

    // Door opens while ignition turns off
    cond_if.door_drv_raw = 1'b1;
    cond_if.ignition_raw = 1'b0;
    expect_ev(5, 4'b1000, 4'b0100, 4'b1010);
    idle(8);

    // Reset mid-debounce on brake; all closed switches re-debounce from zero
    cond_if.brake_raw = 1'b1;
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    expect_ev(5, 4'b1011, 4'b0000, 4'b1011);
    idle(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected events never seen, want 0", exp_q.size());
    end
    checks++;
    if (lvl_now() != 4'b1011) begin
      errors++;
      $display("FAIL final_levels: lvl=%b, want 1011", lvl_now());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
